// File: rtl/gate_drive_guard_pkg.sv
// Shared types and default timing for the half-bridge gate drive guard.
package gate_drive_guard_pkg;

    localparam int DEAD_MIN_DEF  = 40;
    localparam int MIN_PULSE_DEF = 8;
    localparam int FLT_FILT_DEF  = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_HI_ON = 2'd1,
        ST_LO_ON = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gate_drive_guard_fault_filter.sv
// Two-flop synchronizer plus level debounce for the active-low external fault.
module fault_filter
    import gate_drive_guard_pkg::*;
#(
    parameter int FLT_FILT = FLT_FILT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic fault_n,
    output logic fault
);

    localparam int CW = cnt_w(FLT_FILT);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          flt_q;
    logic          differ;

    // Synchronized level disagrees with the current filtered decision.
    assign differ = (~sync_q[1]) != flt_q;
    assign fault  = flt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            flt_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], fault_n};
            if (!differ) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FLT_FILT - 1)) begin
                flt_q <= ~flt_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_drive_guard.sv
// Half-bridge gate drive guard: dead time, minimum pulse, overlap and fault lockout.
module gate_drive_guard
    import gate_drive_guard_pkg::*;
#(
    parameter int DEAD_MIN  = DEAD_MIN_DEF,
    parameter int MIN_PULSE = MIN_PULSE_DEF,
    parameter int FLT_FILT  = FLT_FILT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic ctrl_1,
    input  logic ctrl_2,
    input  logic en,
    input  logic fault_n,
    input  logic fault_clr,
    output logic gate_hi,
    output logic gate_lo,
    output logic fault_latched,
    output logic overlap_err
);

    localparam int DW = cnt_w(DEAD_MIN);
    localparam int PW = cnt_w(MIN_PULSE);

    state_t        state_q, state_nxt;
    logic [DW-1:0] dead_cnt;
    logic [PW-1:0] on_cnt;
    logic          flt, overlap, dead_done, on_done, in_on;

    fault_filter #(.FLT_FILT(FLT_FILT)) u_fault_filter (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .fault_n   (fault_n),
        .fault     (flt)
    );

    assign overlap   = ctrl_1 & ctrl_2;
    assign dead_done = dead_cnt == DW'(DEAD_MIN - 1);
    assign on_done   = on_cnt == PW'(MIN_PULSE - 1);
    assign in_on     = (state_q == ST_HI_ON) || (state_q == ST_LO_ON);

    // Fault outranks everything; overlap and en=0 cut a pulse short.
    always_comb begin
        state_nxt = state_q;
        if (flt) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (en && dead_done && (ctrl_1 ^ ctrl_2))
                        state_nxt = ctrl_1 ? ST_HI_ON : ST_LO_ON;
                end
                ST_HI_ON: begin
                    if (overlap || !en || (!ctrl_1 && on_done))
                        state_nxt = ST_OFF;
                end
                ST_LO_ON: begin
                    if (overlap || !en || (!ctrl_2 && on_done))
                        state_nxt = ST_OFF;
                end
                ST_FAULT: begin
                    if (fault_clr)
                        state_nxt = ST_OFF;
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // Outputs are registered from the next state so gates never see input glitches.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_OFF;
            gate_hi       <= 1'b0;
            gate_lo       <= 1'b0;
            fault_latched <= 1'b0;
            overlap_err   <= 1'b0;
            dead_cnt      <= '0;
            on_cnt        <= '0;
        end else begin
            state_q       <= state_nxt;
            gate_hi       <= state_nxt == ST_HI_ON;
            gate_lo       <= state_nxt == ST_LO_ON;
            fault_latched <= state_nxt == ST_FAULT;

            if (state_q == ST_OFF && state_nxt == ST_OFF)
                dead_cnt <= dead_done ? dead_cnt : dead_cnt + 1'b1;
            else
                dead_cnt <= '0;

            if (in_on && state_nxt == state_q)
                on_cnt <= on_done ? on_cnt : on_cnt + 1'b1;
            else
                on_cnt <= '0;

            if (overlap && state_q != ST_FAULT)
                overlap_err <= 1'b1;
            else if (fault_clr)
                overlap_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_drive_guard.sv
// Directed bench for gate_drive_guard: vector table plus multi-cycle sequences.
module tb_gate_drive_guard;

    logic sys_clk, sys_rst_n;
    logic ctrl_1, ctrl_2, en, fault_n, fault_clr;
    logic gate_hi, gate_lo, fault_latched, overlap_err;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int n;
        bit c1, c2, en, clr;
        bit hi, lo, ovl;
    } vec_t;

    vec_t tbl[$];

    gate_drive_guard dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .ctrl_1        (ctrl_1),
        .ctrl_2        (ctrl_2),
        .en            (en),
        .fault_n       (fault_n),
        .fault_clr     (fault_clr),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .fault_latched (fault_latched),
        .overlap_err   (overlap_err)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    // Advance one edge and settle just past it; inputs are also driven here.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic add(input int n, input bit c1, input bit c2, input bit e, input bit clr,
                       input bit hi, input bit lo, input bit ovl);
        vec_t v;
        v.n = n; v.c1 = c1; v.c2 = c2; v.en = e; v.clr = clr;
        v.hi = hi; v.lo = lo; v.ovl = ovl;
        tbl.push_back(v);
    endtask

    // Release reset with en and ctrl_2 held: gate_lo low for cycles 1..40, high from 41.
    task automatic startup(input string tag);
        sys_rst_n = 1'b1;
        #1;
        for (int i = 1; i <= 45; i++) begin
            chk($sformatf("%s cyc%0d gate_lo", tag, i), int'(gate_lo), (i >= 41) ? 1 : 0);
            chk($sformatf("%s cyc%0d gate_hi", tag, i), int'(gate_hi), 0);
            tick();
        end
    endtask

    initial begin
        int fall, rise, lat;
        bit both;

        sys_rst_n = 1'b0;
        ctrl_1 = 1'b0; ctrl_2 = 1'b1; en = 1'b1; fault_n = 1'b1; fault_clr = 1'b0;
        repeat (3) tick();
        chk("reset gate_hi", int'(gate_hi), 0);
        chk("reset gate_lo", int'(gate_lo), 0);
        chk("reset fault_latched", int'(fault_latched), 0);
        chk("reset overlap_err", int'(overlap_err), 0);

        startup("startup");

        ctrl_2 = 1'b0;
        repeat (50) tick();
        chk("idle gates", int'({gate_hi, gate_lo}), 0);

        // Rows start from OFF with a saturated dead-time counter.
        add(1,  1,0,1,0, 1,0,0);
        add(2,  1,0,1,0, 1,0,0);
        add(5,  0,0,1,0, 1,0,0);
        add(1,  0,0,1,0, 0,0,0);
        add(39, 1,0,1,0, 0,0,0);
        add(1,  1,0,1,0, 1,0,0);
        add(11, 1,0,1,0, 1,0,0);
        add(1,  0,0,1,0, 0,0,0);
        add(39, 1,0,1,0, 0,0,0);
        add(2,  1,0,1,0, 1,0,0);
        add(1,  1,1,1,0, 0,0,1);
        add(5,  0,0,1,0, 0,0,1);
        add(1,  0,0,1,1, 0,0,0);
        add(1,  1,1,1,1, 0,0,1);
        add(1,  0,0,1,1, 0,0,0);
        add(45, 1,0,0,0, 0,0,0);
        add(1,  1,0,1,0, 1,0,0);
        add(1,  1,0,0,0, 0,0,0);
        add(45, 0,0,1,0, 0,0,0);
        add(1,  0,1,1,0, 0,1,0);
        add(7,  0,0,1,0, 0,1,0);
        add(1,  0,0,1,0, 0,0,0);
        add(45, 0,0,1,0, 0,0,0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                ctrl_1 = tbl[i].c1; ctrl_2 = tbl[i].c2; en = tbl[i].en; fault_clr = tbl[i].clr;
                tick();
                chk($sformatf("vec%0d.%0d gate_hi", i, r), int'(gate_hi), int'(tbl[i].hi));
                chk($sformatf("vec%0d.%0d gate_lo", i, r), int'(gate_lo), int'(tbl[i].lo));
                chk($sformatf("vec%0d.%0d overlap_err", i, r), int'(overlap_err), int'(tbl[i].ovl));
                chk($sformatf("vec%0d.%0d fault_latched", i, r), int'(fault_latched), 0);
            end
        end
        ctrl_1 = 1'b0; ctrl_2 = 1'b0; en = 1'b1; fault_clr = 1'b0;

        // High side to low side handover through the dead time.
        ctrl_1 = 1'b1;
        tick();
        chk("handover gate_hi on", int'(gate_hi), 1);
        repeat (10) tick();
        ctrl_1 = 1'b0;
        fall = -1; rise = -1; both = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) ctrl_2 = 1'b1;
            tick();
            if (gate_hi && gate_lo) both = 1'b1;
            if (fall < 0 && !gate_hi) fall = k;
            if (rise < 0 && gate_lo) rise = k;
        end
        chk("handover fall edge", fall, 1);
        chk("handover dead time", rise - fall, 40);
        chk("handover no overlap", int'(both), 0);

        // Short fault glitch is filtered out.
        fault_n = 1'b0;
        repeat (3) tick();
        fault_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("glitch cyc%0d lo/flt", k), int'({gate_lo, fault_latched}), 2);
        end

        // Sustained fault during LO_ON.
        fault_n = 1'b0;
        lat = -1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (lat < 0 && fault_latched) lat = k;
        end
        chk("fault latency", lat, 7);
        chk("fault gates off", int'({gate_hi, gate_lo}), 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_clr ignored", int'(fault_latched), 1);
        fault_n = 1'b1;
        repeat (10) tick();
        chk("fault held after release", int'(fault_latched), 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault cleared", int'(fault_latched), 0);
        chk("post-clear gates", int'({gate_hi, gate_lo}), 0);
        rise = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (rise < 0 && gate_lo) rise = k;
        end
        chk("post-fault dead time", rise, 40);

        // Asynchronous reset during a high-side pulse.
        ctrl_2 = 1'b0;
        repeat (50) tick();
        ctrl_1 = 1'b1;
        tick();
        chk("pre-reset gate_hi", int'(gate_hi), 1);
        repeat (2) tick();
        #4;
        sys_rst_n = 1'b0;
        #1;
        chk("async reset gate_hi", int'(gate_hi), 0);
        chk("async reset gate_lo", int'(gate_lo), 0);
        chk("async reset fault_latched", int'(fault_latched), 0);
        chk("async reset overlap_err", int'(overlap_err), 0);
        ctrl_1 = 1'b0; ctrl_2 = 1'b1;
        tick();
        startup("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_drive_guard.md
GATE_DRIVE_GUARD -- requirements
Module: gate_drive_guard

Interface
REQ-001 SHALL have parameter DEAD_MIN, default 40, minimum both-gates-off cycles between any turn-off and any turn-on (range 1..63).
REQ-002 SHALL have parameter MIN_PULSE, default 8, minimum gate on-time in cycles when a request drops (range 1..63).
REQ-003 SHALL have parameter FLT_FILT, default 4, consecutive synchronized cycles required to change the filtered fault level (range 1..15).
REQ-004 sys_clk  input  1  clock, 50 MHz.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ctrl_1  input  1  high-side request from the PWM generator, synchronous to sys_clk.
REQ-007 ctrl_2  input  1  low-side request from the PWM generator, synchronous to sys_clk.
REQ-008 en  input  1  drive enable; 0 forces both gates off.
REQ-009 fault_n  input  1  external fault, active-low, asynchronous.
REQ-010 fault_clr  input  1  single-cycle clear of the latched fault and overlap flag.
REQ-011 gate_hi  output  1  high-side gate drive.
REQ-012 gate_lo  output  1  low-side gate drive.
REQ-013 fault_latched  output  1  1 while in FAULT.
REQ-014 overlap_err  output  1  sticky flag: both requests seen high together.

Function
REQ-015 FSM states SHALL be OFF, HI_ON, LO_ON, FAULT; gate_hi=1 only in HI_ON, gate_lo=1 only in LO_ON, fault_latched=1 only in FAULT; all are flop-decoded with no combinational input-to-output path.
REQ-016 dead_cnt SHALL be 0 in the first OFF cycle, increment once per OFF cycle, and saturate at DEAD_MIN-1.
REQ-017 OFF->HI_ON (resp. LO_ON) SHALL occur at the edge ending a cycle where dead_cnt==DEAD_MIN-1, en=1, filtered fault=0, and exactly ctrl_1 (resp. ctrl_2) is high; the gate rises 1 cycle after the request is sampled.
REQ-018 on_cnt SHALL be 0 in the first ON cycle, increment per ON cycle, and saturate at MIN_PULSE-1.
REQ-019 ON->OFF on request deassertion SHALL be taken only when on_cnt==MIN_PULSE-1; a request dropped earlier extends the pulse to exactly MIN_PULSE cycles.
REQ-020 ctrl_1 && ctrl_2 sampled high in any state other than FAULT SHALL set overlap_err; in an ON state it SHALL force OFF at the next edge, overriding MIN_PULSE.
REQ-021 en=0 SHALL force ON->OFF at the next edge, overriding MIN_PULSE.
REQ-022 Filtered fault=1 SHALL force any state to FAULT at the next edge; fault has priority over overlap, en and requests on the same edge.
REQ-023 FAULT->OFF SHALL occur only on fault_clr=1 with filtered fault=0; otherwise fault_clr SHALL be ignored; the exit restarts dead_cnt at 0.
REQ-024 fault_clr=1 SHALL clear overlap_err in any state unless an overlap is sampled on the same edge, in which case set wins.
REQ-025 fault_n SHALL pass a 2-FF synchronizer; the filtered fault SHALL toggle only after FLT_FILT consecutive synchronized cycles at the opposite level, giving worst-case assertion latency 2+FLT_FILT+1 edges to gates off.

Reset
REQ-026 Asynchronous assertion of sys_rst_n SHALL immediately force state=OFF, gate_hi=0, gate_lo=0, fault_latched=0, overlap_err=0, dead_cnt=0, on_cnt=0, synchronizer=1, and filtered fault=0, including during an ON pulse.
REQ-027 After release, no gate SHALL rise before DEAD_MIN full OFF cycles.

Structure
REQ-028 Package gate_drive_guard_pkg SHALL hold the state enumeration and the DEAD_MIN/MIN_PULSE/FLT_FILT defaults.
REQ-029 Sub-module fault_filter SHALL implement the synchronizer and debounce of REQ-025; counter widths SHALL be sized by $clog2 of their parameter.

Verification
REQ-030 Release reset with en=1 and ctrl_2=1 held -> gate_lo=0 for cycles 1..40 and 1 from cycle 41; gate_hi=0 throughout.
REQ-031 In HI_ON, drop ctrl_1 and raise ctrl_2 10 cycles later -> gate_lo rises exactly 40 cycles after gate_hi falls, with no overlap.
REQ-032 ctrl_1 pulse of 3 cycles from saturated OFF -> gate_hi high exactly 8 cycles; a 12-cycle pulse -> 12 cycles.
REQ-033 In HI_ON, both requests high for 1 cycle -> gate_hi=0 next cycle, overlap_err=1 sticky until fault_clr.
REQ-034 fault_n low 3 cycles -> no effect; low 10 cycles during LO_ON -> gates 0 and fault_latched=1 within 7 edges; fault_clr while fault_n is low is ignored; fault_clr after release and filter -> OFF, gates resume after 40 cycles.
REQ-035 Assert sys_rst_n mid-HI_ON -> gate_hi=0 asynchronously; after release, REQ-030 timing holds.
